// File: rtl/ripple_adder_pkg.sv
// ripple_adder_pkg
//   Shared constants and types for the 4-bit ripple-carry adder slice.
//   ADDER_WIDTH : operand width in bits (only 4 is supported).
//   add_res_t   : exact adder result {carry_out, sum}, ADDER_WIDTH+1 bits.
package ripple_adder_pkg;

    localparam int ADDER_WIDTH = 4;

    typedef logic [ADDER_WIDTH:0] add_res_t;

endpackage : ripple_adder_pkg

// File: rtl/ripple_adder_4_full_adder.sv
// full_adder
//   One-bit full-adder cell, purely combinational.
//   Ports:
//     a, b : addend bits
//     ci   : carry in
//     s    : sum bit      s  = a ^ b ^ ci
//     co   : carry out    co = a&b | ci&(a^b)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term: a carry into this cell passes straight through when set.
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule : full_adder

// File: rtl/ripple_adder_4.sv
// ripple_adder_4
//   Registered 4-bit unsigned ripple-carry adder built from four chained
//   full_adder cells. {cout,sum} = in1 + in2 + cin, exact, one cycle latency.
//   A new operand set is taken on every rising edge: there is no valid/ready
//   handshake and the block never stalls; outputs change only on clk edges.
//   Optional build macro: RIPPLE_ADDER_4_OVF_EN adds the registered ovf port
//   (two's-complement overflow, c[3] ^ c[4]).
//   Ports:
//     clk  : clock, all state updates on the rising edge
//     rst  : synchronous active-high reset, clears sum/cout(/ovf)
//     in1  : addend A, unsigned
//     in2  : addend B, unsigned
//     cin  : carry into bit 0
//     sum  : registered sum bits [3:0]
//     cout : registered carry out of bit 3
//     ovf  : registered signed overflow (only with RIPPLE_ADDER_4_OVF_EN)
module ripple_adder_4
    import ripple_adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
`ifdef RIPPLE_ADDER_4_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    add_res_t         res;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder u_fa (
            .a  (in1[i]),
            .b  (in2[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign res = {c[WIDTH], s};

    // Plain if/else with no default masking so X/Z on the operands shows up
    // on the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= res[WIDTH-1:0];
            cout <= res[WIDTH];
        end
    end

`ifdef RIPPLE_ADDER_4_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= c[WIDTH-1] ^ c[WIDTH];
        end
    end
`endif

endmodule : ripple_adder_4

// File: tb/tb_ripple_adder_4.sv
// tb_ripple_adder_4
//   Self-checking bench for ripple_adder_4. The driver issues one operand set
//   per cycle and pushes the reference result into exp_q; a separate monitor
//   pops one entry after every rising edge and compares it with the DUT, then
//   checks again later in the same cycle (after the driver has scrambled the
//   operands) that the outputs held. Build with +define+RIPPLE_ADDER_4_OVF_EN
//   to also check ovf.
module tb_ripple_adder_4;

`ifdef RIPPLE_ADDER_4_OVF_EN
    localparam int EW = 6;  // {ovf, cout, sum}
`else
    localparam int EW = 5;  // {cout, sum}
`endif

    logic       clk;
    logic       rst;
    logic [3:0] in1;
    logic [3:0] in2;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
`ifdef RIPPLE_ADDER_4_OVF_EN
    logic       ovf;
`endif

    logic [EW-1:0] exp_q[$];
    int            tests_run = 0;
    int            tests_failed = 0;

    ripple_adder_4 #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .in1  (in1),
        .in2  (in2),
        .cin  (cin),
        .sum  (sum),
`ifdef RIPPLE_ADDER_4_OVF_EN
        .ovf  (ovf),
`endif
        .cout (cout)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Arithmetic view: unsigned sum for {cout,sum}, signed range test for ovf.
    function automatic logic [EW-1:0] model(input logic r, input logic [3:0] a,
                                            input logic [3:0] b, input logic ci);
        int            u;
        int            sa;
        int            sb;
        int            sr;
        logic [4:0]    u5;
        logic          o;
        logic [EW-1:0] ret;
        if (r) return '0;
        u  = int'(a) + int'(b) + int'(ci);
        u5 = u[4:0];
        sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
        sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
        sr = sa + sb + int'(ci);
        o  = (sr > 7) || (sr < -8);
        ret = '0;
        ret[4:0] = u5;
`ifdef RIPPLE_ADDER_4_OVF_EN
        ret[5] = o;
`else
        if (o) ret = ret;  // signed result unused without ovf port
`endif
        return ret;
    endfunction

    function automatic logic [EW-1:0] dut_out();
        logic [EW-1:0] v;
        v = '0;
        v[3:0] = sum;
        v[4]   = cout;
`ifdef RIPPLE_ADDER_4_OVF_EN
        v[5]   = ovf;
`endif
        return v;
    endfunction

    // ---------------- driver ----------------
    // Drive at the falling edge, record the expectation, then scramble the
    // operands mid-cycle after the next rising edge; they get overwritten at
    // the following falling edge so the scramble is never captured.
    task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b,
                         input logic ci);
        @(negedge clk);
        rst = r;
        in1 = a;
        in2 = b;
        cin = ci;
        exp_q.push_back(model(r, a, b, ci));
        @(posedge clk);
        #3;
        in1 = 4'($urandom_range(0, 15));
        in2 = 4'($urandom_range(0, 15));
        cin = 1'($urandom_range(0, 1));
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic [EW-1:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                tests_run++;
                if (dut_out() !== exp) begin
                    tests_failed++;
                    $display("[TB] FAIL result t=%0t got=%b expected=%b", $time, dut_out(), exp);
                end
                #3;  // operands have been scrambled by now
                tests_run++;
                if (dut_out() !== exp) begin
                    tests_failed++;
                    $display("[TB] FAIL hold t=%0t got=%b expected=%b", $time, dut_out(), exp);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        rst = 1'b1;
        in1 = '0;
        in2 = '0;
        cin = 1'b0;

        // Scenario 1: reset for two edges with arbitrary operands.
        repeat (2) drive(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         1'($urandom_range(0, 1)));

        // Directed cases, first one is the first edge out of reset.
        drive(1'b0, 4'b0001, 4'b0000, 1'b0);
        drive(1'b0, 4'b1010, 4'b0011, 1'b0);
        drive(1'b0, 4'b1101, 4'b1010, 1'b1);
        drive(1'b0, 4'b1111, 4'b0000, 1'b1);  // full ripple
        drive(1'b0, 4'b0111, 4'b0001, 1'b0);  // signed overflow
        drive(1'b0, 4'b1111, 4'b1111, 1'b1);  // maximum 31
        drive(1'b0, 4'b1000, 4'b1000, 1'b0);  // negative overflow

        // Back-to-back with reset on the third edge.
        drive(1'b0, 4'b0110, 4'b0101, 1'b1);
        drive(1'b0, 4'b1110, 4'b0011, 1'b0);
        drive(1'b1, 4'b1111, 4'b1111, 1'b1);
        drive(1'b0, 4'b0010, 4'b0100, 1'b1);

        // Every operand combination.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            drive(1'b0, v[3:0], v[7:4], v[8]);
        end

        // Random stream with occasional reset.
        for (int i = 0; i < 200; i++) begin
            drive(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        // Drain: every issued operand set must have been checked.
        repeat (3) @(posedge clk);
        #6;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain left=%0d expected=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_ripple_adder_4
